// File: rtl/sparrow_fetch_queue.sv
// sparrow_fetch_queue: instruction-fetch front end for the sparrow RV32I core.
// Issues sequential word fetches to a one-cycle-latency instruction memory,
// buffers returned words with their PCs in a small FIFO and hands them to
// decode over valid/ready. A redirect flushes everything and restarts fetch.

// Occupancy checker: the issue rule must keep the queue from overflowing.
module sparrow_fetch_queue_chk #(
  parameter int DEPTH = 2,
  parameter int CW    = 2
) (
  input logic          i_clk,
  input logic          i_reset_n,
  input logic [CW-1:0] count,
  input logic          push,
  input logic          pop
);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // A push without a matching pop must never land in a full queue.
  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    !(push && !pop && (count == DEPTH_C)));

  // Stored entry count never exceeds the queue capacity.
  a_count_bound: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    (count <= DEPTH_C));
endmodule

module sparrow_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_1000,
  parameter int          DEPTH    = 2
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_rd_data,
  output logic        o_instr_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_instr_pc,
  input  logic        i_instr_ready
);
  // Pointer width covers DEPTH entries; count needs one more bit to hold DEPTH
  // and, transiently, DEPTH+1 in the occupancy sum.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [31:0]   fetch_pc_r;
  logic [31:0]   req_addr_r;
  logic          rsp_pending_r;
  logic [CW-1:0] count_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [31:0]   instr_mem_r [DEPTH];
  logic [31:0]   pc_mem_r    [DEPTH];

  logic          valid_s;
  logic          pop_s;
  logic          push_s;
  logic          req_s;
  logic [CW-1:0] occupancy_s;
  logic          redirect_pc_unused_s;

  // Low address bits of the redirect target are dropped (word-aligned fetch).
  assign redirect_pc_unused_s = ^i_redirect_pc[1:0];

  // Handshake qualifiers and the issue decision: only fetch when the word is
  // guaranteed a slot once it returns, counting this cycle's pop.
  always_comb begin
    valid_s     = (count_r != {CW{1'b0}});
    pop_s       = valid_s & i_instr_ready;
    push_s      = rsp_pending_r & ~i_redirect;
    occupancy_s = count_r + {{(CW-1){1'b0}}, rsp_pending_r}
                          - {{(CW-1){1'b0}}, pop_s};
    req_s       = i_reset_n & ~i_redirect & (occupancy_s < DEPTH_C);
  end

  // Drive the memory request and the head of the queue; outputs read zero
  // while the queue is empty so stale entries never leak out.
  always_comb begin
    o_imem_req    = req_s;
    o_imem_addr   = fetch_pc_r;
    o_instr_valid = valid_s;
    if (valid_s) begin
      o_instr    = instr_mem_r[rd_ptr_r];
      o_instr_pc = pc_mem_r[rd_ptr_r];
    end else begin
      o_instr    = 32'h0000_0000;
      o_instr_pc = 32'h0000_0000;
    end
  end

  // Fetch PC, in-flight tracking, pointers and count; redirect wins over all.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      fetch_pc_r    <= RESET_PC;
      req_addr_r    <= 32'h0000_0000;
      rsp_pending_r <= 1'b0;
      count_r       <= {CW{1'b0}};
      rd_ptr_r      <= {PW{1'b0}};
      wr_ptr_r      <= {PW{1'b0}};
    end else if (i_redirect) begin
      fetch_pc_r    <= {i_redirect_pc[31:2], 2'b00};
      rsp_pending_r <= 1'b0;
      count_r       <= {CW{1'b0}};
      rd_ptr_r      <= {PW{1'b0}};
      wr_ptr_r      <= {PW{1'b0}};
    end else begin
      rsp_pending_r <= req_s;
      if (req_s) begin
        fetch_pc_r <= fetch_pc_r + 32'd4;
        req_addr_r <= fetch_pc_r;
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Queue storage: returned word paired with the address that fetched it.
  always_ff @(posedge i_clk) begin
    if (push_s) begin
      instr_mem_r[wr_ptr_r] <= i_imem_rd_data;
      pc_mem_r[wr_ptr_r]    <= req_addr_r;
    end
  end

  sparrow_fetch_queue_chk #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_chk (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .count     (count_r),
    .push      (push_s),
    .pop       (pop_s)
  );
endmodule

// File: tb/tb_sparrow_fetch_queue.sv
// Directed bench for sparrow_fetch_queue: a one-cycle-latency memory model
// returns 0xA0000000 | addr, and accepted PCs / issued addresses are logged
// and compared against hand-computed sequences.
module tb_sparrow_fetch_queue;
  logic        clk;
  logic        reset_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  int total;
  int bad;
  logic [31:0] acc_q [$];
  logic [31:0] req_q [$];

  sparrow_fetch_queue #(
    .RESET_PC (32'h0000_1000),
    .DEPTH    (2)
  ) dut (
    .i_clk          (clk),
    .i_reset_n      (reset_n),
    .i_redirect     (redirect),
    .i_redirect_pc  (redirect_pc),
    .o_imem_req     (imem_req),
    .o_imem_addr    (imem_addr),
    .i_imem_rd_data (imem_rd_data),
    .o_instr_valid  (instr_valid),
    .o_instr        (instr),
    .o_instr_pc     (instr_pc),
    .i_instr_ready  (instr_ready)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous instruction memory with one-cycle read latency.
  always @(posedge clk) begin
    if (imem_req) imem_rd_data <= 32'hA000_0000 | imem_addr;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs mid-cycle, then log what the cycle does.
  task automatic drive(input logic rstn, input logic redir, input logic [31:0] rpc,
                       input logic rdy);
    @(negedge clk);
    reset_n     = rstn;
    redirect    = redir;
    redirect_pc = rpc;
    instr_ready = rdy;
    #1;
    if (reset_n && instr_valid && instr_ready && !redirect) begin
      acc_q.push_back(instr_pc);
      chk("instr_data", instr, 32'hA000_0000 | instr_pc);
    end
    if (imem_req) req_q.push_back(imem_addr);
  endtask

  task automatic chk_seq(input string tag, input logic [31:0] q [$],
                         input logic [31:0] start, input int n);
    logic [31:0] e;
    chk({tag, "_len"}, 32'(q.size()), 32'(n));
    for (int i = 0; i < n && i < q.size(); i++) begin
      e = start + 32'(4 * i);
      chk(tag, q[i], e);
    end
  endtask

  task automatic clear_logs();
    acc_q.delete();
    req_q.delete();
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    reset_n     = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0000_0000;
    instr_ready = 1'b0;

    // Reset state.
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_req",   {31'd0, imem_req},    32'd0);
    chk("rst_addr",  imem_addr, 32'h0000_1000);
    chk("rst_instr", instr,     32'h0000_0000);
    chk("rst_pc",    instr_pc,  32'h0000_0000);

    // Streaming from reset with ready high.
    clear_logs();
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    chk("t1_c0_req",   {31'd0, imem_req},    32'd1);
    chk("t1_c0_addr",  imem_addr, 32'h0000_1000);
    chk("t1_c0_valid", {31'd0, instr_valid}, 32'd0);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    chk("t1_c1_addr",  imem_addr, 32'h0000_1004);
    chk("t1_c1_valid", {31'd0, instr_valid}, 32'd0);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    chk("t1_c2_valid", {31'd0, instr_valid}, 32'd1);
    chk("t1_c2_instr", instr,    32'hA000_1000);
    chk("t1_c2_pc",    instr_pc, 32'h0000_1000);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b1);
      chk("t1_no_gap", {31'd0, instr_valid}, 32'd1);
    end
    chk_seq("t1_acc", acc_q, 32'h0000_1000, 7);
    chk_seq("t1_req", req_q, 32'h0000_1000, 9);

    // Backpressure: queue fills, head holds, then drains in order.
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    clear_logs();
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    chk("t2_req_drop", {31'd0, imem_req}, 32'd0);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    chk("t2_valid",  {31'd0, instr_valid}, 32'd1);
    chk("t2_pc",     instr_pc, 32'h0000_1000);
    chk("t2_req_c3", {31'd0, imem_req}, 32'd0);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    chk("t2_hold_pc",    instr_pc, 32'h0000_1000);
    chk("t2_hold_instr", instr,    32'hA000_1000);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    chk("t2_resume_addr", imem_addr, 32'h0000_1008);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 32'h0, 1'b1);
    chk_seq("t2_acc", acc_q, 32'h0000_1000, 6);
    chk_seq("t2_req", req_q, 32'h0000_1000, 8);

    // Ready toggling 1,0,1,0: every PC exactly once, in order.
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    clear_logs();
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 32'h0, (i % 2) == 0);
    chk_seq("t3_acc", acc_q, 32'h0000_1000, 7);

    // Redirect with a stored entry and a response in flight.
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    clear_logs();
    drive(1'b1, 1'b1, 32'h0000_2002, 1'b0);
    chk("t4_req_in_r",   {31'd0, imem_req},    32'd0);
    chk("t4_valid_in_r", {31'd0, instr_valid}, 32'd1);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    chk("t4_r1_valid", {31'd0, instr_valid}, 32'd0);
    chk("t4_r1_req",   {31'd0, imem_req},    32'd1);
    chk("t4_r1_addr",  imem_addr, 32'h0000_2000);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    chk("t4_r2_valid", {31'd0, instr_valid}, 32'd0);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    chk("t4_r3_valid", {31'd0, instr_valid}, 32'd1);
    chk("t4_r3_pc",    instr_pc, 32'h0000_2000);
    chk("t4_r3_instr", instr,    32'hA000_2000);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 32'h0, 1'b1);
    chk_seq("t4_acc", acc_q, 32'h0000_2000, 4);
    chk_seq("t4_req", req_q, 32'h0000_2000, 6);

    // Back-to-back redirects: only the last target is fetched.
    clear_logs();
    drive(1'b1, 1'b1, 32'h0000_3000, 1'b1);
    chk("t5_req_r0", {31'd0, imem_req}, 32'd0);
    drive(1'b1, 1'b1, 32'h0000_4000, 1'b1);
    chk("t5_req_r1", {31'd0, imem_req}, 32'd0);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    chk("t5_addr", imem_addr, 32'h0000_4000);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    chk("t5_pc", instr_pc, 32'h0000_4000);
    chk_seq("t5_req", req_q, 32'h0000_4000, 3);
    chk_seq("t5_acc", acc_q, 32'h0000_4000, 1);

    // Address wrap past the top of memory.
    clear_logs();
    drive(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 32'h0, 1'b1);
    chk_seq("t6_req", req_q, 32'hFFFF_FFFC, 5);
    chk_seq("t6_acc", acc_q, 32'hFFFF_FFFC, 3);

    // Reset mid-stream takes effect immediately, then fetch restarts.
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t7_valid", {31'd0, instr_valid}, 32'd0);
    chk("t7_req",   {31'd0, imem_req},    32'd0);
    chk("t7_addr",  imem_addr, 32'h0000_1000);
    clear_logs();
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    chk("t7_restart_addr", imem_addr, 32'h0000_1000);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    chk("t7_restart_valid", {31'd0, instr_valid}, 32'd1);
    chk("t7_restart_pc",    instr_pc, 32'h0000_1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
